rgb_frame_ctl: RTL

RGB_FRAME_CTL -- requirements
Module: rgb_frame_ctl

---
 rtl/rgb_pkg.sv | 32 +++
 rtl/rgb_pix_fifo.sv | 67 ++++++
 rtl/rgb_frame_ctl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB frame controller: widths, FSM encodings,
// wire-order field offsets and the debug view of the receive FSM.
package rgb_pkg;

  localparam int PIX_W = 24;
  localparam int IDX_W = 10;
  localparam int CNT_W = 5;

  // Field offsets in wire order (G first on the wire, then R, then B)
  localparam int G_OFF = 16;
  localparam int R_OFF = 8;
  localparam int B_OFF = 0;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    RECV = 2'd1,
    PASS = 2'd2
  } state_t;

  // Debug view of the receive FSM, exported by the top for checkers
  typedef struct packed {
    state_t            state;
    logic [CNT_W-1:0]  bitcnt;
    logic [IDX_W-1:0]  idx;
  } dbg_t;

  // Reorder a wire-order {G,R,B} word into {R,G,B}
  function automatic logic [PIX_W-1:0] wire_to_rgb(input logic [PIX_W-1:0] w);
    return {w[R_OFF +: 8], w[G_OFF +: 8], w[B_OFF +: 8]};
  endfunction

endpackage

// File: rtl/rgb_pix_fifo.sv
// Small synchronous FIFO holding {idx, pixel} words between the receive
// FSM and the pixel consumer. A push into a full buffer is taken only when
// a pop happens in the same cycle. full/empty are registered flags.
module rgb_pix_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Next occupancy from the accepted push/pop pair
  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + 1'b1;
    end else if (!do_push && do_pop) begin
      count_nxt = count - 1'b1;
    end
  end

  // Storage, pointers and registered occupancy flags
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/rgb_frame_ctl.sv
// RGB frame controller: assembles sampled serial bits into 24-bit pixels,
// claims the first NUM_LEDS pixels after each stream reset, and hands them
// to a consumer through a two-entry buffer.
// Optional statistics counters (frame_cnt, drop_cnt) are built when the
// macro RGB_FRAME_CTL_STATS_EN is defined.
//
// Handshake: pix_valid/pix_ready follow strict valid/ready rules. A pixel
// transfers on a clock edge where both are high; while pix_valid=1 and
// pix_ready=0, pix_data and pix_idx hold; pix_valid never drops without a
// transfer (except on rst).
module rgb_frame_ctl
  import rgb_pkg::*;
#(
  parameter int NUM_LEDS   = 60,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_strobe,
  input  logic             in_stream_reset,
  output logic [PIX_W-1:0] pix_data,
  output logic [IDX_W-1:0] pix_idx,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             frame_start,
  output logic             frame_done,
  output logic             err_ovf,
  output logic             err_part,
  input  logic             err_clr,
  output dbg_t             dbg
`ifdef RGB_FRAME_CTL_STATS_EN
  ,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      drop_cnt
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PIX_W - 1);

  state_t             state;
  logic [CNT_W-1:0]   bitcnt;
  logic [IDX_W-1:0]   idx;
  // Holds the first 23 bits; the 24th joins straight from in_bit on push
  logic [PIX_W-2:0]   shifter;

  logic               is_data;
  logic               is_sreset;
  logic               push_req;
  logic               pop;
  logic               drop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [PIX_W+IDX_W-1:0] fifo_wdata;
  logic [PIX_W+IDX_W-1:0] fifo_rdata;

  assign is_data    = in_strobe & ~in_stream_reset;
  assign is_sreset  = in_strobe & in_stream_reset;
  assign push_req   = (state == RECV) & is_data & (bitcnt == LAST_BIT);
  assign fifo_wdata = {idx, wire_to_rgb({shifter, in_bit})};
  assign pop        = pix_valid & pix_ready;
  assign drop       = push_req & fifo_full & ~pop;

  assign pix_valid  = ~fifo_empty;
  assign pix_data   = fifo_rdata[PIX_W-1:0];
  assign pix_idx    = fifo_rdata[PIX_W +: IDX_W];

  assign dbg.state  = state;
  assign dbg.bitcnt = bitcnt;
  assign dbg.idx    = idx;

  rgb_pix_fifo #(
    .W     (PIX_W + IDX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Receive FSM: stream-reset sync, bit assembly, frame pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SYNC;
      bitcnt      <= '0;
      idx         <= '0;
      shifter     <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_start <= is_sreset;
      frame_done  <= 1'b0;
      if (is_sreset) begin
        state   <= RECV;
        bitcnt  <= '0;
        idx     <= '0;
        shifter <= '0;
      end else if (is_data && state == RECV) begin
        if (bitcnt == LAST_BIT) begin
          bitcnt  <= '0;
          shifter <= '0;
          if (idx == LAST_IDX) begin
            // Remaining bits in this frame belong to downstream LEDs
            frame_done <= 1'b1;
            state      <= PASS;
          end else begin
            idx <= idx + 1'b1;
          end
        end else begin
          shifter <= {shifter[PIX_W-3:0], in_bit};
          bitcnt  <= bitcnt + 1'b1;
        end
      end
    end
  end

  // Sticky error flags; a same-cycle set beats err_clr
  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf  <= 1'b0;
      err_part <= 1'b0;
    end else begin
      if (drop) begin
        err_ovf <= 1'b1;
      end else if (err_clr) begin
        err_ovf <= 1'b0;
      end
      if (is_sreset && state == RECV && bitcnt != '0) begin
        err_part <= 1'b1;
      end else if (err_clr) begin
        err_part <= 1'b0;
      end
    end
  end

`ifdef RGB_FRAME_CTL_STATS_EN
  // Saturating frame and drop counters, cleared only by rst
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (frame_start && frame_cnt != 16'hFFFF) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (drop && drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
